// File: rtl/routing_pkg.sv
// Shared routing helpers: channel count and flattened-bus slice offsets.
package routing_pkg;

   function automatic int unsigned num_ch(input int unsigned s);
      return 32'd1 << s;
   endfunction

   // Low bit of channel k in a bus of T-bit lanes.
   function automatic int unsigned slice_lo(input int unsigned k, input int unsigned t);
      return k * t;
   endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry holding slot with valid/ready; a draining slot may be refilled in the same cycle.
module stream_demux_slot #(
   parameter int unsigned T = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [T-1:0] load_data,
   input  logic         out_ready,
   output logic         full,
   output logic [T-1:0] data,
   output logic         free
);

   logic         r_full;
   logic [T-1:0] r_data;
   logic         w_drain;

   assign w_drain = r_full & out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (load) begin
         r_full <= 1'b1;
         r_data <= load_data;
      end else if (w_drain) begin
         r_full <= 1'b0;
      end
   end

   assign full = r_full;
   assign data = r_data;
   assign free = ~r_full | w_drain;

endmodule

// File: rtl/stream_demux.sv
// Registered flow-controlled 1-to-2**S demux; STREAM_DEMUX_BCAST_EN adds the in_bcast port.
module stream_demux
   import routing_pkg::*;
#(
   parameter int unsigned S = 2,
   parameter int unsigned T = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [S-1:0]            in_sel,
   input  logic [T-1:0]            in_data,
`ifdef STREAM_DEMUX_BCAST_EN
   input  logic                    in_bcast,
`endif
   output logic [num_ch(S)-1:0]    out_valid,
   input  logic [num_ch(S)-1:0]    out_ready,
   output logic [num_ch(S)*T-1:0]  out_data
);

   localparam int unsigned N = num_ch(S);

   logic [N-1:0] w_free;
   logic [N-1:0] w_load;
   logic         w_bcast;
   logic         w_xfer;

`ifdef STREAM_DEMUX_BCAST_EN
   assign w_bcast = in_bcast;
`else
   assign w_bcast = 1'b0;
`endif

   // Broadcast waits for every slot so it is never partial.
   assign in_ready = ~reset & (w_bcast ? &w_free : w_free[in_sel]);
   assign w_xfer   = in_valid & in_ready;

   for (genvar k = 0; k < N; k++) begin : g_slot
      assign w_load[k] = w_xfer & (w_bcast | (in_sel == S'(k)));

      stream_demux_slot #(
         .T (T)
      ) u_slot (
         .clk       (clk),
         .reset     (reset),
         .load      (w_load[k]),
         .load_data (in_data),
         .out_ready (out_ready[k]),
         .full      (out_valid[k]),
         .data      (out_data[slice_lo(k, T) +: T]),
         .free      (w_free[k])
      );
   end

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench: S=2/T=1 instance for most scenarios, S=3/T=8 for drain-and-refill.
module tb_stream_demux;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_reset, a_in_valid, a_in_ready;
   logic [1:0] a_in_sel;
   logic [0:0] a_in_data;
   logic [3:0] a_out_valid, a_out_ready, a_out_data;
`ifdef STREAM_DEMUX_BCAST_EN
   logic       a_in_bcast;
`endif

   logic        b_reset, b_in_valid, b_in_ready;
   logic [2:0]  b_in_sel;
   logic [7:0]  b_in_data;
   logic [7:0]  b_out_valid, b_out_ready;
   logic [63:0] b_out_data;
`ifdef STREAM_DEMUX_BCAST_EN
   logic        b_in_bcast;
`endif

   int n_vec = 0;
   int n_err = 0;

   stream_demux #(.S(2), .T(1)) dut_a (
      .clk       (clk),
      .reset     (a_reset),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_sel    (a_in_sel),
      .in_data   (a_in_data),
`ifdef STREAM_DEMUX_BCAST_EN
      .in_bcast  (a_in_bcast),
`endif
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_data  (a_out_data)
   );

   stream_demux #(.S(3), .T(8)) dut_b (
      .clk       (clk),
      .reset     (b_reset),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_sel    (b_in_sel),
      .in_data   (b_in_data),
`ifdef STREAM_DEMUX_BCAST_EN
      .in_bcast  (b_in_bcast),
`endif
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_reset = 1'b1; a_in_valid = 1'b1; a_in_sel = 2'd0; a_in_data = 1'b1;
      a_out_ready = 4'hF;
      b_reset = 1'b1; b_in_valid = 1'b0; b_in_sel = 3'd0; b_in_data = 8'h00;
      b_out_ready = 8'hFF;
`ifdef STREAM_DEMUX_BCAST_EN
      a_in_bcast = 1'b0;
      b_in_bcast = 1'b0;
`endif

      // Reset held two cycles with a word offered
      step();
      check_eq("rst1_valid", 32'(a_out_valid), 32'h0);
      check_eq("rst1_ready", 32'(a_in_ready), 32'h0);
      step();
      check_eq("rst2_valid", 32'(a_out_valid), 32'h0);
      check_eq("rst2_ready", 32'(a_in_ready), 32'h0);
      check_eq("rst2_data", 32'(a_out_data), 32'h0);
      a_reset = 1'b0; a_in_valid = 1'b0;
      #1 check_eq("rel_ready", 32'(a_in_ready), 32'h1);

      // Address sweep
      a_in_valid = 1'b1; a_in_data = 1'b1;
      a_in_sel = 2'd0; step(); check_eq("sweep0", 32'(a_out_valid), 32'h1);
      a_in_sel = 2'd1; step(); check_eq("sweep1", 32'(a_out_valid), 32'h2);
      a_in_sel = 2'd2; step(); check_eq("sweep2", 32'(a_out_valid), 32'h4);
      a_in_sel = 2'd3; step(); check_eq("sweep3", 32'(a_out_valid), 32'h8);
      a_in_valid = 1'b0; step();
      check_eq("sweep_empty", 32'(a_out_valid), 32'h0);
      check_eq("sweep_hold", 32'(a_out_data), 32'hF);

      // Independent stall on channel 2
      a_out_ready = 4'b1011;
      a_in_valid = 1'b1; a_in_sel = 2'd2; a_in_data = 1'b0;
      #1 check_eq("stall_rdy0", 32'(a_in_ready), 32'h1);
      step(); check_eq("stall_v0", 32'(a_out_valid), 32'h4);
      a_in_data = 1'b1;
      #1 check_eq("stall_blk", 32'(a_in_ready), 32'h0);
      step();
      check_eq("stall_v1", 32'(a_out_valid), 32'h4);
      check_eq("stall_d2", 32'(a_out_data[2]), 32'h0);
      check_eq("stall_blk2", 32'(a_in_ready), 32'h0);
      a_in_sel = 2'd1;
      #1 check_eq("stall_ch1_rdy", 32'(a_in_ready), 32'h1);
      step(); check_eq("stall_v2", 32'(a_out_valid), 32'h6);
      a_in_valid = 1'b0;
      step();
      check_eq("stall_v3", 32'(a_out_valid), 32'h4);
      check_eq("stall_d2b", 32'(a_out_data[2]), 32'h0);
      a_out_ready = 4'hF;
      step(); check_eq("stall_release", 32'(a_out_valid), 32'h0);

      // Reset mid-stream with every slot full
      a_out_ready = 4'h0; a_in_valid = 1'b1; a_in_data = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_in_sel = 2'(i);
         step();
      end
      a_in_valid = 1'b0;
      check_eq("fill_all", 32'(a_out_valid), 32'hF);
      check_eq("fill_data", 32'(a_out_data), 32'hF);
      a_reset = 1'b1;
      step();
      check_eq("mid_rst_valid", 32'(a_out_valid), 32'h0);
      check_eq("mid_rst_data", 32'(a_out_data), 32'h0);
      check_eq("mid_rst_ready", 32'(a_in_ready), 32'h0);
      a_reset = 1'b0;

`ifdef STREAM_DEMUX_BCAST_EN
      // Broadcast blocked by stalled slot 3, then released
      a_out_ready = 4'b0111; a_in_valid = 1'b1; a_in_sel = 2'd3; a_in_data = 1'b1;
      step(); check_eq("bc_pre", 32'(a_out_valid), 32'h8);
      a_in_bcast = 1'b1; a_in_sel = 2'd0;
      #1 check_eq("bc_blk", 32'(a_in_ready), 32'h0);
      step(); check_eq("bc_noload", 32'(a_out_valid), 32'h8);
      a_out_ready = 4'hF;
      #1 check_eq("bc_rdy", 32'(a_in_ready), 32'h1);
      step(); check_eq("bc_all", 32'(a_out_valid), 32'hF);
      a_in_valid = 1'b0; a_in_bcast = 1'b0;
`endif

      // Same-cycle drain and refill, S=3 T=8
      b_reset = 1'b0;
      b_in_valid = 1'b1; b_in_sel = 3'd0; b_in_data = 8'hA5;
      #1 check_eq("b_rdy0", 32'(b_in_ready), 32'h1);
      step();
      check_eq("b_v0", 32'(b_out_valid), 32'h01);
      check_eq("b_d0", 32'(b_out_data[7:0]), 32'hA5);
      b_in_data = 8'h3C;
      #1 check_eq("b_refill_rdy", 32'(b_in_ready), 32'h1);
      step();
      check_eq("b_v1", 32'(b_out_valid), 32'h01);
      check_eq("b_d1", 32'(b_out_data[7:0]), 32'h3C);
      b_in_valid = 1'b0;
      step();
      check_eq("b_v2", 32'(b_out_valid), 32'h00);
      check_eq("b_hold", 32'(b_out_data[7:0]), 32'h3C);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
